// File: rtl/cmd_seq_buffer.sv
// cmd_seq_buffer: command-byte buffer between the OLED control FSM and the
// SPI byte engine. One load captures up to DEPTH bytes. The bytes are then
// streamed one at a time over a valid/ready handshake. The final byte is
// flagged, and done pulses once the sequence has completed.
// Optional feature macro: CMD_DC_FLAG_EN adds a per-byte D/C flag
// (i_dc_bus in, o_dc out), so one load can mix command and pixel-data bytes.
module cmd_seq_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [CNT_W-1:0]        i_num_cmd,
    input  logic [DEPTH*DATA_W-1:0] i_cmd_bus,
`ifdef CMD_DC_FLAG_EN
    input  logic [DEPTH-1:0]        i_dc_bus,
    output logic                    o_dc,
`endif
    output logic                    o_busy,
    output logic                    o_load_err,
    output logic [DATA_W-1:0]       o_cmd,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic                    o_last_byte,
    output logic                    o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        index_q, index_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DEPTH*DATA_W-1:0] storage_q, storage_d;
    logic [DATA_W-1:0]       cmd_q, cmd_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    load_err_q, load_err_d;
    logic [CNT_W-1:0]        load_count;
    logic [DATA_W-1:0]       next_byte;
`ifdef CMD_DC_FLAG_EN
    logic [DEPTH-1:0]        dc_store_q, dc_store_d;
    logic                    dc_q, dc_d;
    logic                    next_dc;
`endif

    // Saturate the requested count, and select the byte (and flag) that follows the current index.
    always_comb begin
        load_count = (i_num_cmd > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_num_cmd;
        next_byte  = '0;
`ifdef CMD_DC_FLAG_EN
        next_dc    = 1'b0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (index_q == CNT_W'(k)) begin
                next_byte = storage_q[k*DATA_W +: DATA_W];
`ifdef CMD_DC_FLAG_EN
                next_dc   = dc_store_q[k];
`endif
            end
        end
    end

    // Next-state logic. Clear overrides load, and load overrides the handshake.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        storage_d   = storage_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 1'b0;
        load_err_d  = 1'b0;
`ifdef CMD_DC_FLAG_EN
        dc_store_d  = dc_store_q;
        dc_d        = dc_q;
`endif
        if (i_clear) begin
            state_d     = ST_IDLE;
            index_d     = '0;
            count_d     = '0;
            storage_d   = '0;
            cmd_d       = '0;
            cmd_valid_d = 1'b0;
`ifdef CMD_DC_FLAG_EN
            dc_store_d  = '0;
            dc_d        = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_load) begin
                        storage_d = i_cmd_bus;
                        count_d   = load_count;
`ifdef CMD_DC_FLAG_EN
                        dc_store_d = i_dc_bus;
`endif
                        if (load_count != '0) begin
                            state_d     = ST_STREAM;
                            index_d     = CNT_W'(1);
                            cmd_d       = i_cmd_bus[DATA_W-1:0];
                            cmd_valid_d = 1'b1;
`ifdef CMD_DC_FLAG_EN
                            dc_d        = i_dc_bus[0];
`endif
                        end else begin
                            state_d     = ST_DONE;
                            index_d     = '0;
                            cmd_d       = '0;
                            cmd_valid_d = 1'b0;
`ifdef CMD_DC_FLAG_EN
                            dc_d        = 1'b0;
`endif
                        end
                    end
                end
                ST_STREAM: begin
                    load_err_d = i_load;
                    if (cmd_valid_q && i_cmd_ready) begin
                        if (index_q < count_q) begin
                            index_d = index_q + CNT_W'(1);
                            cmd_d   = next_byte;
`ifdef CMD_DC_FLAG_EN
                            dc_d    = next_dc;
`endif
                        end else begin
                            state_d     = ST_DONE;
                            cmd_d       = '0;
                            cmd_valid_d = 1'b0;
`ifdef CMD_DC_FLAG_EN
                            dc_d        = 1'b0;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    load_err_d = i_load;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        last_d = cmd_valid_d && (index_d == count_d);
    end

    // State and registered outputs. Reset asynchronously to an empty, idle buffer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            storage_q   <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef CMD_DC_FLAG_EN
            dc_store_q  <= '0;
            dc_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            storage_q   <= storage_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_err_q  <= load_err_d;
`ifdef CMD_DC_FLAG_EN
            dc_store_q  <= dc_store_d;
            dc_q        <= dc_d;
`endif
        end
    end

    assign o_busy      = busy_q;
    assign o_load_err  = load_err_q;
    assign o_cmd       = cmd_q;
    assign o_cmd_valid = cmd_valid_q;
    assign o_last_byte = last_q;
    assign o_done      = done_q;
`ifdef CMD_DC_FLAG_EN
    assign o_dc        = dc_q;
`endif

endmodule

// File: tb/tb_cmd_seq_buffer.sv
// tb_cmd_seq_buffer: scoreboard bench for cmd_seq_buffer. Each load pushes its
// expected byte sequence into a queue. A negedge monitor compares every
// presented byte against the queue head and accounts for done/load_err pulses.
// Build with CMD_DC_FLAG_EN to also cover the D/C flag.
module tb_cmd_seq_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              dc;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_reset = 1'b1;
    logic                    i_clear = 1'b0;
    logic                    i_load = 1'b0;
    logic [CNT_W-1:0]        i_num_cmd = '0;
    logic [DEPTH*DATA_W-1:0] i_cmd_bus = '0;
    logic                    i_cmd_ready = 1'b0;
    logic                    o_busy, o_load_err, o_cmd_valid, o_last_byte, o_done;
    logic [DATA_W-1:0]       o_cmd;
`ifdef CMD_DC_FLAG_EN
    logic [DEPTH-1:0]        i_dc_bus = '0;
    logic                    o_dc;
`endif

    int   n_vectors = 0;
    int   n_miscompares = 0;
    exp_t sb[$];
    int   done_pending = 0;
    int   err_expected = 0;
    int   xfer_count = 0;
    logic prev_done = 1'b0;
    exp_t mon_e;
    logic [DEPTH*DATA_W-1:0] stim_bus;

    cmd_seq_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_load      (i_load),
        .i_num_cmd   (i_num_cmd),
        .i_cmd_bus   (i_cmd_bus),
`ifdef CMD_DC_FLAG_EN
        .i_dc_bus    (i_dc_bus),
        .o_dc        (o_dc),
`endif
        .o_busy      (o_busy),
        .o_load_err  (o_load_err),
        .o_cmd       (o_cmd),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_last_byte (o_last_byte),
        .o_done      (o_done)
    );

    // 100 MHz clock.
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic randBus(output logic [DEPTH*DATA_W-1:0] bus);
        for (int k = 0; k < DEPTH; k++) bus[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    // Issue one load. The model keeps min(n, DEPTH) bytes; byte k sits in bus bits [k*8-1 -: 8].
    task automatic applyStimulus(input int n, input logic [DEPTH*DATA_W-1:0] bus, input logic [DEPTH-1:0] dc);
        int   n_sat;
        exp_t e;
        n_sat = (n > DEPTH) ? DEPTH : n;
        for (int k = 1; k <= n_sat; k++) begin
            e.data = bus[k*DATA_W-1 -: DATA_W];
            e.last = (k == n_sat);
            e.dc   = dc[k-1];
            sb.push_back(e);
        end
        done_pending++;
        i_load    = 1'b1;
        i_num_cmd = CNT_W'(n);
        i_cmd_bus = bus;
`ifdef CMD_DC_FLAG_EN
        i_dc_bus  = dc;
`endif
        tick();
        i_load = 1'b0;
    endtask

    // A load while a sequence is still streaming must be ignored and flagged.
    task automatic applyBusyLoad();
        logic [DEPTH*DATA_W-1:0] bus;
        randBus(bus);
        err_expected++;
        i_load    = 1'b1;
        i_num_cmd = CNT_W'($urandom_range(0, 20));
        i_cmd_bus = bus;
        tick();
        i_load = 1'b0;
    endtask

    task automatic flushModel();
        sb.delete();
        done_pending = 0;
    endtask

    task automatic waitIdle(input int bound, input int ready_pct, input bit allow_busy_load);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || done_pending != 0) && cyc < bound) begin
            i_cmd_ready = ($urandom_range(0, 99) < ready_pct);
            if (allow_busy_load && sb.size() != 0 && $urandom_range(0, 19) == 0) applyBusyLoad();
            else tick();
            cyc++;
        end
        if (sb.size() != 0 || done_pending != 0) checkOutput("idle_timeout", 32'(sb.size() + done_pending), 0);
    endtask

    // Monitor: compare every presented byte with the scoreboard head and pop it on transfer.
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_cmd_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'(o_cmd), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb[0];
                    checkOutput("cmd", 32'(o_cmd), 32'(mon_e.data));
                    checkOutput("last", 32'(o_last_byte), 32'(mon_e.last));
`ifdef CMD_DC_FLAG_EN
                    checkOutput("dc", 32'(o_dc), 32'(mon_e.dc));
`endif
                    checkOutput("busy_while_valid", 32'(o_busy), 1);
                    if (i_cmd_ready) begin
                        void'(sb.pop_front());
                        xfer_count++;
                    end
                end
            end else begin
                checkOutput("cmd_zero_idle", 32'(o_cmd), 0);
                checkOutput("last_idle", 32'(o_last_byte), 0);
`ifdef CMD_DC_FLAG_EN
                checkOutput("dc_idle", 32'(o_dc), 0);
`endif
            end
            if (o_done) begin
                checkOutput("done_expected", 32'(done_pending > 0), 1);
                checkOutput("done_after_all_bytes", 32'(sb.size()), 0);
                checkOutput("done_single_cycle", 32'(prev_done), 0);
                if (done_pending > 0) done_pending--;
            end
            if (o_load_err) begin
                checkOutput("load_err_expected", 32'(err_expected > 0), 1);
                if (err_expected > 0) err_expected--;
            end
            prev_done = o_done;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed scenarios followed by randomized loads, stalls, busy loads and clears.
    initial begin
        int n;
        logic [DEPTH-1:0] dc;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_valid", 32'(o_cmd_valid), 0);
        checkOutput("rst_cmd", 32'(o_cmd), 0);
        checkOutput("rst_last", 32'(o_last_byte), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_err", 32'(o_load_err), 0);
        i_reset = 1'b0;
        tick();

        // Three bytes streamed back to back with ready held high
        i_cmd_ready = 1'b1;
        stim_bus = '0;
        stim_bus[7:0]   = 8'hA0;
        stim_bus[15:8]  = 8'hA1;
        stim_bus[23:16] = 8'hA2;
        applyStimulus(3, stim_bus, '0);
        checkOutput("t1_valid_b1", 32'(o_cmd_valid), 1);
        checkOutput("t1_cmd_b1", 32'(o_cmd), 32'hA0);
        checkOutput("t1_busy", 32'(o_busy), 1);
        tick();
        checkOutput("t1_cmd_b2", 32'(o_cmd), 32'hA1);
        tick();
        checkOutput("t1_cmd_b3", 32'(o_cmd), 32'hA2);
        checkOutput("t1_last_b3", 32'(o_last_byte), 1);
        tick();
        checkOutput("t1_valid_end", 32'(o_cmd_valid), 0);
        checkOutput("t1_done_early", 32'(o_done), 0);
        tick();
        checkOutput("t1_done", 32'(o_done), 1);
        checkOutput("t1_busy_end", 32'(o_busy), 0);
        tick();
        checkOutput("t1_done_off", 32'(o_done), 0);
        waitIdle(20, 100, 0);

        // Two bytes, ready pattern 1,0,0,1: the second byte holds through the stall
        stim_bus = '0;
        stim_bus[7:0]  = 8'hAE;
        stim_bus[15:8] = 8'hAF;
        applyStimulus(2, stim_bus, '0);
        tick();
        i_cmd_ready = 1'b0;
        checkOutput("t2_cmd_stall1", 32'(o_cmd), 32'hAF);
        tick();
        checkOutput("t2_cmd_stall2", 32'(o_cmd), 32'hAF);
        checkOutput("t2_valid_stall2", 32'(o_cmd_valid), 1);
        tick();
        i_cmd_ready = 1'b1;
        tick();
        checkOutput("t2_valid_end", 32'(o_cmd_valid), 0);
        waitIdle(20, 100, 0);

        // Zero-length load: no byte, done on the second cycle after the load
        applyStimulus(0, stim_bus, '0);
        checkOutput("t3_valid", 32'(o_cmd_valid), 0);
        checkOutput("t3_done_c1", 32'(o_done), 0);
        checkOutput("t3_busy_c1", 32'(o_busy), 1);
        tick();
        checkOutput("t3_done_c2", 32'(o_done), 1);
        tick();
        checkOutput("t3_done_c3", 32'(o_done), 0);
        waitIdle(20, 100, 0);

        // Oversized count saturates at DEPTH
        xfer_count = 0;
        randBus(stim_bus);
        applyStimulus(20, stim_bus, 16'hFFFF);
        waitIdle(100, 100, 0);
        checkOutput("t4_byte_count", 32'(xfer_count), DEPTH);

        // Load during stream is flagged and ignored
        i_cmd_ready = 1'b0;
        randBus(stim_bus);
        applyStimulus(4, stim_bus, 16'h0005);
        tick();
        applyBusyLoad();
        checkOutput("t5_load_err", 32'(o_load_err), 1);
        checkOutput("t5_cmd_kept", 32'(o_cmd), 32'(stim_bus[7:0]));
        tick();
        checkOutput("t5_load_err_off", 32'(o_load_err), 0);
        waitIdle(50, 100, 0);

        // Clear together with load: back to idle with no done and no load_err
        i_cmd_ready = 1'b0;
        randBus(stim_bus);
        applyStimulus(4, stim_bus, '0);
        tick();
        i_clear = 1'b1;
        i_load  = 1'b1;
        tick();
        i_clear = 1'b0;
        i_load  = 1'b0;
        flushModel();
        checkOutput("t5_clr_busy", 32'(o_busy), 0);
        checkOutput("t5_clr_valid", 32'(o_cmd_valid), 0);
        checkOutput("t5_clr_err", 32'(o_load_err), 0);
        repeat (3) begin
            tick();
            checkOutput("t5_clr_no_done", 32'(o_done), 0);
        end

        // D/C pattern 1010 over four bytes
        i_cmd_ready = 1'b1;
        randBus(stim_bus);
        applyStimulus(4, stim_bus, 16'h000A);
        waitIdle(50, 100, 0);

        // Async reset in the middle of byte 2 of 4
        randBus(stim_bus);
        applyStimulus(4, stim_bus, 16'h000F);
        tick();
        #1;
        i_reset = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(o_cmd_valid), 0);
        checkOutput("t6_rst_cmd", 32'(o_cmd), 0);
        checkOutput("t6_rst_busy", 32'(o_busy), 0);
        checkOutput("t6_rst_last", 32'(o_last_byte), 0);
`ifdef CMD_DC_FLAG_EN
        checkOutput("t6_rst_dc", 32'(o_dc), 0);
`endif
        flushModel();
        #1;
        i_reset = 1'b0;
        repeat (4) begin
            tick();
            checkOutput("t6_rst_no_done", 32'(o_done), 0);
        end

        // Randomized loads with random back-pressure, busy loads and clears
        for (int it = 0; it < 40; it++) begin
            n  = $urandom_range(0, 20);
            dc = DEPTH'($urandom);
            randBus(stim_bus);
            applyStimulus(n, stim_bus, dc);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 6)) begin
                    i_cmd_ready = ($urandom_range(0, 1) == 1);
                    tick();
                end
                i_cmd_ready = 1'b0;
                i_clear = 1'b1;
                tick();
                i_clear = 1'b0;
                flushModel();
            end
            waitIdle(300, 60, 1);
        end

        repeat (4) tick();
        checkOutput("end_err_accounted", 32'(err_expected), 0);
        checkOutput("end_sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
